// File: rtl/core_pkg.sv
// Shared core definitions for the execute-stage forwarding logic.
//   XLEN_DEF / REG_AW_DEF : default datapath and register-index widths
//   fwd_src_e             : origin of a resolved operand (debug / perf)
//   cand_origin()         : maps a flattened candidate slot back to its origin
package core_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [2:0] {
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_BUF,
    FWD_RF
  } fwd_src_e;

  // Candidate slots are laid out EX lanes, MEM lanes, WB lanes, then buffer entries.
  function automatic fwd_src_e cand_origin(input int cand, input int ntgt);
    if (cand < ntgt)          return FWD_EX;
    else if (cand < 2 * ntgt) return FWD_MEM;
    else if (cand < 3 * ntgt) return FWD_WB;
    else                      return FWD_BUF;
  endfunction

endpackage

// File: rtl/bypass_mux.sv
// Priority operand select for one source register.
//   idx       : source register index (0 = hardwired zero, never forwarded)
//   rf_data   : register-file read value, used when nothing matches
//   cand_tgt  : flattened candidate destination indices, slot 0 = highest priority
//   cand_data : flattened candidate results, same slot order
//   operand   : resolved operand
//   origin    : where the operand came from (only with BYPASS_PERF_EN)
module bypass_mux
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int NCAND  = 4,
  parameter int NTGT   = 2
) (
  input  logic [REG_AW-1:0]       idx,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [NCAND*REG_AW-1:0] cand_tgt,
  input  logic [NCAND*XLEN-1:0]   cand_data,
  output logic [XLEN-1:0]         operand
`ifdef BYPASS_PERF_EN
  ,output fwd_src_e               origin
`endif
);

  // Walk from lowest to highest priority so the last match written wins.
  // A zero target can never match because idx == 0 skips the search.
  always_comb begin
    operand = rf_data;
`ifdef BYPASS_PERF_EN
    origin  = FWD_RF;
`endif
    if (idx != '0) begin
      for (int c = NCAND - 1; c >= 0; c--) begin
        if (cand_tgt[c*REG_AW +: REG_AW] == idx) begin
          operand = cand_data[c*XLEN +: XLEN];
`ifdef BYPASS_PERF_EN
          origin  = cand_origin(c, NTGT);
`endif
        end
      end
    end
  end

endmodule

// File: rtl/bypass_network.sv
// Operand forwarding and load-use hazard unit for the execute stage.
// Optional macro: BYPASS_PERF_EN adds stall_cycles and fwd_hits counters.
//   clk, rst_n                    : core clock, async active-low reset
//   src_idx, rf_data              : per-source register index and RF read data
//   id_bubble                     : instruction in execute is a bubble
//   ex_/mem_/wb_ tgt, data        : per-lane destination index and result
//   ex_/mem_/wb_ bubble           : stage holds a bubble (its targets are ignored)
//   ex_is_load, mem_is_load       : stage holds a load
//   flush                         : clears the stall-replay buffer
//   operand                       : resolved operands
//   stall                         : load-use hazard, hold decode/execute
//   buf_ovf                       : sticky, replay buffer dropped a valid entry
module bypass_network
  import core_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int NSRC      = 2,
  parameter int NTGT      = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSRC*REG_AW-1:0]   src_idx,
  input  logic [NSRC*XLEN-1:0]     rf_data,
  input  logic                     id_bubble,
  input  logic [NTGT*REG_AW-1:0]   ex_tgt,
  input  logic [NTGT*REG_AW-1:0]   mem_tgt,
  input  logic [NTGT*REG_AW-1:0]   wb_tgt,
  input  logic [NTGT*XLEN-1:0]     ex_data,
  input  logic [NTGT*XLEN-1:0]     mem_data,
  input  logic [NTGT*XLEN-1:0]     wb_data,
  input  logic                     ex_bubble,
  input  logic                     mem_bubble,
  input  logic                     wb_bubble,
  input  logic                     ex_is_load,
  input  logic                     mem_is_load,
  input  logic                     flush,
  output logic [NSRC*XLEN-1:0]     operand,
  output logic                     stall,
  output logic                     buf_ovf
`ifdef BYPASS_PERF_EN
  ,output logic [31:0]             stall_cycles,
  output logic [31:0]              fwd_hits
`endif
);

  localparam int LANE_AW = NTGT * REG_AW;
  localparam int LANE_DW = NTGT * XLEN;
  localparam int NCAND   = (3 + BUF_DEPTH) * NTGT;

  logic [LANE_AW-1:0] ex_tgt_m, mem_tgt_m, wb_tgt_m;
  logic [LANE_AW-1:0] buf_tgt  [BUF_DEPTH];
  logic [LANE_DW-1:0] buf_data [BUF_DEPTH];
  logic [NCAND*REG_AW-1:0] cand_tgt;
  logic [NCAND*XLEN-1:0]   cand_data;
  logic ex_hazard, mem_hazard;

  // A bubble stage looks like it writes register 0, which never matches.
  assign ex_tgt_m  = ex_bubble  ? '0 : ex_tgt;
  assign mem_tgt_m = mem_bubble ? '0 : mem_tgt;
  assign wb_tgt_m  = wb_bubble  ? '0 : wb_tgt;

  always_comb begin
    cand_tgt  = '0;
    cand_data = '0;
    cand_tgt [0*LANE_AW +: LANE_AW] = ex_tgt_m;
    cand_tgt [1*LANE_AW +: LANE_AW] = mem_tgt_m;
    cand_tgt [2*LANE_AW +: LANE_AW] = wb_tgt_m;
    cand_data[0*LANE_DW +: LANE_DW] = ex_data;
    cand_data[1*LANE_DW +: LANE_DW] = mem_data;
    cand_data[2*LANE_DW +: LANE_DW] = wb_data;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      cand_tgt [(3+k)*LANE_AW +: LANE_AW] = buf_tgt[k];
      cand_data[(3+k)*LANE_DW +: LANE_DW] = buf_data[k];
    end
  end

  always_comb begin
    ex_hazard  = 1'b0;
    mem_hazard = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      for (int l = 0; l < NTGT; l++) begin
        if (ex_tgt_m[l*REG_AW +: REG_AW] != '0 &&
            ex_tgt_m[l*REG_AW +: REG_AW] == src_idx[s*REG_AW +: REG_AW])
          ex_hazard = 1'b1;
        if (mem_tgt_m[l*REG_AW +: REG_AW] != '0 &&
            mem_tgt_m[l*REG_AW +: REG_AW] == src_idx[s*REG_AW +: REG_AW])
          mem_hazard = 1'b1;
      end
    end
    stall = !id_bubble && ((ex_is_load && ex_hazard) || (mem_is_load && mem_hazard));
  end

  // While stalled the held RF reads go stale, so WB results retiring during
  // the stall are kept here (entry 0 newest) until execute proceeds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BUF_DEPTH; k++) begin
        buf_tgt[k]  <= '0;
        buf_data[k] <= '0;
      end
      buf_ovf <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < BUF_DEPTH; k++) buf_tgt[k] <= '0;
    end else if (stall) begin
      buf_tgt[0]  <= wb_tgt_m;
      buf_data[0] <= wb_data;
      for (int k = 1; k < BUF_DEPTH; k++) begin
        buf_tgt[k]  <= buf_tgt[k-1];
        buf_data[k] <= buf_data[k-1];
      end
      if (buf_tgt[BUF_DEPTH-1] != '0) buf_ovf <= 1'b1;
    end else begin
      for (int k = 0; k < BUF_DEPTH; k++) buf_tgt[k] <= '0;
    end
  end

`ifdef BYPASS_PERF_EN
  fwd_src_e    src_origin [NSRC];
  logic [31:0] hit_cnt;
`endif

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    bypass_mux #(
      .XLEN  (XLEN),
      .REG_AW(REG_AW),
      .NCAND (NCAND),
      .NTGT  (NTGT)
    ) u_mux (
      .idx      (src_idx[s*REG_AW +: REG_AW]),
      .rf_data  (rf_data[s*XLEN +: XLEN]),
      .cand_tgt (cand_tgt),
      .cand_data(cand_data),
      .operand  (operand[s*XLEN +: XLEN])
`ifdef BYPASS_PERF_EN
      ,.origin  (src_origin[s])
`endif
    );
  end

`ifdef BYPASS_PERF_EN
  always_comb begin
    hit_cnt = '0;
    for (int s = 0; s < NSRC; s++)
      if (src_origin[s] != FWD_RF) hit_cnt = hit_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      fwd_hits     <= '0;
    end else begin
      if (stall)      stall_cycles <= stall_cycles + 32'd1;
      if (!id_bubble) fwd_hits     <= fwd_hits + hit_cnt;
    end
  end
`endif

endmodule

// File: doc/bypass_network.md
Name: bypass_network

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the pipelined core's execute stage.
- Generalises the fixed two-source / two-target / two-deep forwarding scheme to NSRC source operands, NTGT writeback lanes per stage and a BUF_DEPTH stall-replay buffer.
- Sits between the decode/execute pipeline register and the ALU.
- Selects each operand from the youngest in-flight producer and raises stall on load-use hazards.
- Captures WB results retired during stall cycles, because the held register-file read values are stale.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width; index 0 is hardwired zero and never forwarded.
- NSRC, 2, number of source operands resolved per cycle.
- NTGT, 2, writeback lanes per pipeline stage.
- BUF_DEPTH, 2, stall-replay buffer entries (>=1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- src_idx  in  NSRC*REG_AW  source register indices, lane i at [i*REG_AW +: REG_AW].
- rf_data  in  NSRC*XLEN  register-file read data per source.
- id_bubble  in  1  instruction in execute is a bubble.
- ex_tgt / mem_tgt / wb_tgt  in  NTGT*REG_AW each  destination indices latched in EX output, MEM and WB.
- ex_data / mem_data / wb_data  in  NTGT*XLEN each  corresponding results.
- ex_bubble / mem_bubble / wb_bubble  in  1 each  stage holds a bubble.
- ex_is_load / mem_is_load  in  1 each  stage holds a load.
- flush  in  1  halt/branch flush; clears the replay buffer.
- operand  out  NSRC*XLEN  resolved operands.
- stall  out  1  hold decode/execute; inject a bubble.
- buf_ovf  out  1  sticky: replay buffer dropped a valid entry.

Behaviour:
- Reset: all buffer targets = 0, buffer data = 0, buf_ovf = 0. stall and operand are combinational from inputs.
- Operand priority per source s with idx != 0, first match wins:
  - ex lane 0..NTGT-1
  - mem lane 0..NTGT-1
  - wb lane 0..NTGT-1
  - buffer entry 0 (newest) .. BUF_DEPTH-1 (oldest), lanes in order
  - rf_data
- Stage tgt equal to 0 never matches. A stage tgt is treated as 0 when its bubble flag is set.
- idx == 0: operand = rf_data (expected zero); no forwarding.
- stall = !id_bubble && ((ex_is_load && !ex_bubble && any nonzero ex_tgt matches any src_idx) || (mem_is_load && !mem_bubble && any nonzero mem_tgt matches any src_idx)).
- Buffer update, each posedge:
  - flush = 1: all buffer targets cleared.
  - Else stall = 1: entry0 <= {wb_tgt masked by wb_bubble, wb_data}; entry k <= entry k-1.
  - Else: all buffer targets cleared; data is don't-care.
- Overflow: if stall = 1 and the oldest entry has any nonzero tgt, that entry is shifted out and buf_ovf is set. buf_ovf clears only on reset.
- Latency: forwarding 0 cycles. A WB result captured at stall edge n is visible from cycle n+1 until the stall drops.
- Simultaneous flush and stall: flush wins.
- Reset mid-stall: buffer emptied immediately (asynchronous).

Optional Feature:
- Macro: BYPASS_PERF_EN.
- When defined, adds outputs:
  - stall_cycles  out  32: increments each cycle stall = 1; wraps at 2^32.
  - fwd_hits  out  32: increments per source resolved from any non-rf origin in a non-bubble cycle; adds up to NSRC per cycle.
  - Both counters reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - XLEN_DEF and REG_AW_DEF constants.
  - typedef fwd_src_e {FWD_EX, FWD_MEM, FWD_WB, FWD_BUF, FWD_RF}, used for debug/perf.
- One sub-module: bypass_mux. Priority select for a single source over a flattened candidate vector; instantiated NSRC times by generate.

Test Plan:
- ex_tgt lane0 = 3, ex_data = 0x11, mem_tgt lane0 = 3, mem_data = 0x22, src0 = 3, no load -> operand0 = 0x11, stall = 0.
- ex_is_load = 1, ex_tgt lane1 = 7, src1 = 7, id_bubble = 0 -> stall = 1. Same stimulus with id_bubble = 1 -> stall = 0.
- 2-cycle stall with wb_tgt = 5 / 0x55, then wb_tgt = 6 / 0x66, src0 = 5, src1 = 6, WB stages then empty -> after stall drops, operands = 0x55 and 0x66; next non-stall cycle the buffer is cleared.
- BUF_DEPTH = 2, 3-cycle stall with valid wb_tgt each cycle -> buf_ovf = 1 after the 3rd edge and stays set until rst_n low.
- src0 = 0, ex_tgt = 0, ex_data = 0xFFFF -> operand0 = rf_data0. flush together with stall -> buffer targets all 0 next cycle.
- rst_n low mid-stall with buffer full -> buffer targets = 0 and buf_ovf = 0 immediately; with BYPASS_PERF_EN, stall_cycles = 0.
